// File: rtl/data_mem_bytesel.sv
// Byte-addressable data memory: RISC-V byte/half/word loads and stores, alignment checks, hardware clear after reset.
// Read latency 0 (REG_READ=0) or 1 (REG_READ=1); no backpressure, stores and loads are ignored while busy.
module data_mem_bytesel #(
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 32,
  parameter int REG_READ = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_en,
  input  logic              rd_en,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              busy,
  output logic              access_err,
  output logic              err_sticky
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [31:0]      mem [DEPTH];
  logic [0:0]       state;
  logic [IDX_W-1:0] clr_cnt;
  logic [IDX_W-1:0] widx;
  logic [1:0]       lane;
  logic             ready;

  assign widx  = address[IDX_W+1:2];
  assign lane  = address[1:0];
  assign ready = (state == READY);
  assign busy  = (state == CLEAR);

  // Upper address bits do not take part in decoding; accesses wrap modulo DEPTH.
  if (ADDR_W > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[ADDR_W-1:IDX_W+2];
  end

  // Store decode: lane enables, replicated data and legality.
  logic [3:0]  st_be;
  logic [31:0] st_dat;
  logic        st_ok;

  always_comb begin
    st_be  = 4'b0000;
    st_dat = write_data;
    st_ok  = 1'b0;
    case (funct3)
      3'b000: begin
        st_ok  = 1'b1;
        st_be  = 4'b0001 << lane;
        st_dat = {4{write_data[7:0]}};
      end
      3'b001: begin
        st_ok  = ~lane[0];
        st_be  = lane[1] ? 4'b1100 : 4'b0011;
        st_dat = {2{write_data[15:0]}};
      end
      3'b010: begin
        st_ok  = (lane == 2'b00);
        st_be  = 4'b1111;
        st_dat = write_data;
      end
      default: begin
        st_ok  = 1'b0;
      end
    endcase
  end

  // Load decode: lane extraction and sign/zero extension.
  logic [31:0] ld_word;
  logic [31:0] ld_shift;
  logic [31:0] ld_val;
  logic [31:0] ld_res;
  logic        ld_ok;

  assign ld_word  = mem[widx];
  assign ld_shift = ld_word >> {lane, 3'b000};

  always_comb begin
    ld_ok  = 1'b0;
    ld_val = '0;
    case (funct3)
      3'b000: begin
        ld_ok  = 1'b1;
        ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      end
      3'b001: begin
        ld_ok  = ~lane[0];
        ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      end
      3'b010: begin
        ld_ok  = (lane == 2'b00);
        ld_val = ld_word;
      end
      3'b100: begin
        ld_ok  = 1'b1;
        ld_val = {24'h0, ld_shift[7:0]};
      end
      3'b101: begin
        ld_ok  = ~lane[0];
        ld_val = {16'h0, ld_shift[15:0]};
      end
      default: begin
        ld_ok  = 1'b0;
      end
    endcase
  end

  assign ld_res = ld_ok ? ld_val : '0;

  // A store in the same cycle as a load wins; the load is dropped silently.
  logic st_fire;
  logic ld_fire;
  logic err_now;
  logic clr_we;

  assign st_fire = ready & wrt_en & st_ok;
  assign ld_fire = ready & rd_en & ~wrt_en;
  assign err_now = ready & ((wrt_en & ~st_ok) | (rd_en & ~wrt_en & ~ld_ok));
  assign clr_we  = rst & (state == CLEAR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      access_err <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      access_err <= err_now;
      err_sticky <= err_sticky | err_now;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == IDX_W'(DEPTH - 1)) begin
          state <= READY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (st_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem[widx][8*b +: 8] <= st_dat[8*b +: 8];
        end
      end
    end
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [31:0] rd_q;
    always_ff @(posedge clk) begin
      if (!rst) begin
        rd_q <= '0;
      end else if (ld_fire) begin
        rd_q <= ld_res;
      end
    end
    assign read_data = rd_q;
  end else begin : g_comb_read
    assign read_data = (ready && !wrt_en) ? ld_res : '0;
  end

endmodule

// File: tb/tb_data_mem_bytesel.sv
// Drives a combinational-read and a registered-read instance (DEPTH=8) with the same directed vectors
// and checks both every cycle against a word-array model, plus hand-computed load results.
module tb_data_mem_bytesel;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrt_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;

  logic [31:0] rd0, rd1;
  logic        busy0, busy1, err0, err1, stk0, stk1;

  always #5 clk = ~clk;

  data_mem_bytesel #(.DEPTH(8), .ADDR_W(32), .REG_READ(0)) u_comb (
    .clk(clk), .rst(rst), .wrt_en(wrt_en), .rd_en(rd_en), .funct3(funct3),
    .address(address), .write_data(write_data), .read_data(rd0),
    .busy(busy0), .access_err(err0), .err_sticky(stk0)
  );

  data_mem_bytesel #(.DEPTH(8), .ADDR_W(32), .REG_READ(1)) u_reg (
    .clk(clk), .rst(rst), .wrt_en(wrt_en), .rd_en(rd_en), .funct3(funct3),
    .address(address), .write_data(write_data), .read_data(rd1),
    .busy(busy1), .access_err(err1), .err_sticky(stk1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: plain word array, clear modelled as a countdown of busy cycles.
  logic [31:0] mem_m [8];
  int          clear_left = 8;
  logic        m_err = 1'b0;
  logic        m_sticky = 1'b0;
  logic [31:0] m_rd0 = '0;
  logic [31:0] m_rd1 = '0;
  bit          chk_en = 1'b0;
  int          busy_seen = 0;

  function automatic bit mdl_legal(input bit is_st, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      3'd4:    return !is_st;
      3'd5:    return !is_st && ((a % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, b, h;
    int sh;
    w  = mem_m[int'((a >> 2) & 32'd7)];
    sh = 8 * int'(a % 4);
    b  = (w >> sh) & 32'hFF;
    h  = (w >> sh) & 32'hFFFF;
    if (!mdl_legal(1'b0, f3, a)) return 32'h0;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd2:    return w;
      3'd4:    return b;
      default: return h;
    endcase
  endfunction

  task automatic mdl_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int idx, sh;
    idx  = int'((a >> 2) & 32'd7);
    sh   = 8 * int'(a % 4);
    mask = (f3 == 3'd0) ? (32'hFF << sh) : (f3 == 3'd1) ? (32'hFFFF << sh) : 32'hFFFFFFFF;
    mem_m[idx] = (mem_m[idx] & ~mask) | ((wd << sh) & mask);
  endtask

  // One clock cycle; inputs change 1 time unit after posedge.
  task automatic cyc(input logic r, input logic we, input logic re, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input bit lit, input logic [31:0] lv, input string nm);
    rst = r; wrt_en = we; rd_en = re; funct3 = f3; address = a; write_data = wd;
    m_rd0 = (clear_left == 0 && !we) ? mdl_load(f3, a) : 32'h0;
    @(negedge clk);
    if (busy0 === 1'b1) busy_seen++;
    if (lit) check({nm, "_comb"}, rd0, lv);
    @(posedge clk);
    if (!r) begin
      clear_left = 8; m_err = 1'b0; m_sticky = 1'b0; m_rd1 = '0;
      for (int i = 0; i < 8; i++) mem_m[i] = '0;
    end else if (clear_left > 0) begin
      clear_left--; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (we) begin
        if (mdl_legal(1'b1, f3, a)) mdl_store(f3, a, wd);
        else m_err = 1'b1;
      end else if (re) begin
        m_rd1 = mdl_load(f3, a);
        m_err = !mdl_legal(1'b0, f3, a);
      end
      m_sticky = m_sticky | m_err;
    end
    chk_en = 1'b1;
    #1;
    if (lit) check({nm, "_reg"}, rd1, lv);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    cyc(1'b1, 1'b1, 1'b0, f3, a, wd, 1'b0, 32'h0, "");
  endtask

  task automatic ld(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] lv);
    cyc(1'b1, 1'b0, 1'b1, f3, a, 32'h0, 1'b1, lv, nm);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_busy_c",   32'(busy0), 32'(clear_left > 0));
      check("mdl_busy_r",   32'(busy1), 32'(clear_left > 0));
      check("mdl_err_c",    32'(err0),  32'(m_err));
      check("mdl_err_r",    32'(err1),  32'(m_err));
      check("mdl_sticky_c", 32'(stk0),  32'(m_sticky));
      check("mdl_sticky_r", 32'(stk1),  32'(m_sticky));
      check("mdl_rd_comb",  rd0, m_rd0);
      check("mdl_rd_reg",   rd1, m_rd1);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, "");
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_rd_reg", rd1, 32'h0);
    check("rst_sticky", 32'(stk1), 32'd0);

    // Release reset; a store in the third clear cycle must be dropped.
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) st(3'd2, 32'h00, 32'hDEADBEEF);
      else idle();
    end
    check("clear_busy_cycles", busy_seen, 32'd8);
    ld("lw00_after_clear", 3'd2, 32'h00, 32'h0);

    st(3'd2, 32'h10, 32'h8899AABB);
    st(3'd0, 32'h11, 32'h0000005C);
    ld("lw10",  3'd2, 32'h10, 32'h88995CBB);
    ld("lb13",  3'd0, 32'h13, 32'hFFFFFF88);
    ld("lbu13", 3'd4, 32'h13, 32'h00000088);
    ld("lb10",  3'd0, 32'h10, 32'hFFFFFFBB);
    ld("lbu11", 3'd4, 32'h11, 32'h0000005C);
    ld("lh10",  3'd1, 32'h10, 32'h00005CBB);
    ld("lh12",  3'd1, 32'h12, 32'hFFFF8899);
    ld("lhu12", 3'd5, 32'h12, 32'h00008899);

    st(3'd1, 32'h22, 32'h0000F00D);
    ld("lh22",  3'd1, 32'h22, 32'hFFFFF00D);
    ld("lhu22", 3'd5, 32'h22, 32'h0000F00D);
    ld("lh20",  3'd1, 32'h20, 32'h0);

    st(3'd2, 32'h06, 32'hFFFFFFFF);
    check("err_sw06", 32'(err0), 32'd1);
    check("sticky_sw06", 32'(stk0), 32'd1);
    idle();
    check("err_pulse_end", 32'(err1), 32'd0);
    check("sticky_held", 32'(stk1), 32'd1);
    ld("lw04_unchanged", 3'd2, 32'h04, 32'h0);
    ld("lh03_misaligned", 3'd1, 32'h03, 32'h0);
    check("err_lh03", 32'(err1), 32'd1);
    st(3'd4, 32'h08, 32'h12345678);
    check("err_st_f3_100", 32'(err0), 32'd1);
    ld("lw08_unchanged", 3'd2, 32'h08, 32'h0);
    ld("ld_f3_011", 3'd3, 32'h08, 32'h0);
    check("err_ld_f3_011", 32'(err0), 32'd1);

    st(3'd2, 32'h24, 32'h00001234);
    ld("lw04_wrap", 3'd2, 32'h04, 32'h00001234);

    ld("lw10_pre", 3'd2, 32'h10, 32'h88995CBB);
    cyc(1'b1, 1'b1, 1'b1, 3'd2, 32'h18, 32'hCAFEF00D, 1'b0, 32'h0, "");
    check("both_rd_hold", rd1, 32'h88995CBB);
    check("both_no_err", 32'(err1), 32'd0);
    ld("lw18", 3'd2, 32'h18, 32'hCAFEF00D);

    // Single-cycle reset from READY re-runs the clear.
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, "");
    check("rerst_sticky", 32'(stk0), 32'd0);
    check("rerst_busy", 32'(busy1), 32'd1);
    busy_seen = 0;
    for (int i = 0; i < 10; i++) idle();
    check("reclear_busy_cycles", busy_seen, 32'd8);
    ld("lw10_recleared", 3'd2, 32'h10, 32'h0);
    ld("lw18_recleared", 3'd2, 32'h18, 32'h0);

    chk_en = 1'b0;
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
